// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit carry-lookahead adder among NUM_REQ requesters.
// Grant is combinational in IDLE; the registered result is valid two cycles later and held until i_rsp_ready.
module carry_lookahead_adder_64bit (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_s,
  output logic        o_cout
);
  logic [63:0] w_g, w_p, w_c;
  logic [15:0] w_gg, w_gp;
  logic [16:0] w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // 4-bit lookahead groups; group carries chain on group generate/propagate
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    w_gc[0] = i_cin;
    for (int k = 0; k < 16; k++) begin
      w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_gc[k+1]  = w_gg[k] | (w_gp[k] & w_gc[k]);
    end
  end

  assign o_s    = w_p ^ w_c;
  assign o_cout = w_gc[16];
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*64-1:0] i_a_flat,
  input  logic [NUM_REQ*64-1:0] i_b_flat,
  input  logic [NUM_REQ-1:0]    i_cin,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_busy,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [63:0]           o_rsp_sum,
  output logic                  o_rsp_cout
);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr, r_id, r_rsp_id;
  logic [63:0]     r_a, r_b, r_rsp_sum;
  logic            r_cin, r_rsp_valid, r_rsp_cout;
  logic [ID_W-1:0] w_winner, w_next_ptr;
  logic [ID_W:0]   w_idx;
  logic            w_found, w_cout;
  logic [63:0]     w_sum;

  // First set request at or after r_rr_ptr, wrapping at NUM_REQ
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ))
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + ID_W'(1);

  always_comb begin
    o_grant = '0;
    if (r_state == S_IDLE && w_found && !i_rst)
      o_grant[w_winner] = 1'b1;
  end

  carry_lookahead_adder_64bit u_cla (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_cin  (r_cin),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= i_a_flat[64*w_winner +: 64];
            r_b      <= i_b_flat[64*w_winner +: 64];
            r_cin    <= i_cin[w_winner];
            r_id     <= w_winner;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          r_rsp_sum   <= w_sum;
          r_rsp_cout  <= w_cout;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
endmodule
